// File: rtl/mux_sel_scanner.sv
// Round-robin select sequencer for the 6-to-1 data mux: dwell, then valid/ready offer per enabled channel.
// Optional MUXSEQ_TIMEOUT_EN adds an OFFER timeout that skips a stalled channel and pulses timeout_err.
module mux_sel_scanner #(
    parameter int NUM_CH  = 6,
    parameter int DWELL   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sel_ready,
    output logic [2:0]        sel,
    output logic              sel_valid,
    output logic              busy,
    output logic              frame_done
`ifdef MUXSEQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_OFFER} state_t;

    state_t        state;
    logic [DW-1:0] dwell_cnt;
    logic          stop_lat;

    logic [2:0]    first_ch;
    logic [2:0]    nxt_above;
    logic          found;
    logic [2:0]    nxt_ch;
    logic          nxt_wrap;
    logic          to_hit;
    logic          adv;

    // Descending scan: the last hit is the lowest qualifying index.
    always_comb begin
        first_ch  = '0;
        nxt_above = '0;
        found     = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                first_ch = 3'(i);
                if (3'(i) > sel) begin
                    nxt_above = 3'(i);
                    found     = 1'b1;
                end
            end
        end
        nxt_ch   = found ? nxt_above : first_ch;
        nxt_wrap = !found;
    end

`ifdef MUXSEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] to_cnt;

    // A real handshake on the final cycle wins over the timeout.
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1)) && !sel_ready;
`else
    assign to_hit = 1'b0;
`endif

    assign adv = (state == S_OFFER) && (sel_ready || to_hit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            sel        <= SEL_IDLE;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dwell_cnt  <= '0;
            stop_lat   <= 1'b0;
`ifdef MUXSEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef MUXSEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    stop_lat <= 1'b0;
                    if (start && (|ch_en)) begin
                        state     <= S_DWELL;
                        sel       <= first_ch;
                        dwell_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_DWELL: begin
                    stop_lat <= stop_lat | stop;
                    if (dwell_cnt == DW'(DWELL - 1)) begin
                        state     <= S_OFFER;
                        sel_valid <= 1'b1;
`ifdef MUXSEQ_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                S_OFFER: begin
                    if (adv) begin
                        // With an empty mask there is no next channel, hence no wrap.
                        frame_done <= (|ch_en) && nxt_wrap;
                        sel_valid  <= 1'b0;
                        stop_lat   <= 1'b0;
`ifdef MUXSEQ_TIMEOUT_EN
                        timeout_err <= to_hit;
`endif
                        if (stop_lat || stop || !(|ch_en)) begin
                            state <= S_IDLE;
                            sel   <= SEL_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_DWELL;
                            sel       <= nxt_ch;
                            dwell_cnt <= '0;
                        end
                    end else begin
                        stop_lat <= stop_lat | stop;
`ifdef MUXSEQ_TIMEOUT_EN
                        to_cnt   <= to_cnt + TW'(1);
`endif
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    sel       <= SEL_IDLE;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner: reset, full/sparse scans, backpressure+stop, mid-scan reset, optional timeout.
module tb_mux_sel_scanner;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       stop;
    logic [5:0] ch_en;
    logic       sel_ready;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       frame_done;
`ifdef MUXSEQ_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    mux_sel_scanner #(.NUM_CH(6), .DWELL(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .ch_en      (ch_en),
        .sel_ready  (sel_ready),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef MUXSEQ_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Called at the first negedge after sel enters a channel, with sel_ready=1.
    task automatic run_ch(input logic [2:0] s, input logic [2:0] nxt, input logic fd);
        chk("entry_sel", sel, s);
        chk("entry_valid", sel_valid, 0);
        chk("entry_busy", busy, 1);
        step(3);
        chk("dwell_valid", sel_valid, 0);
        step(1);
        chk("offer_valid", sel_valid, 1);
        chk("offer_sel", sel, s);
        step(1);
        chk("next_sel", sel, nxt);
        chk("frame_done", frame_done, fd);
        chk("next_valid", sel_valid, 0);
        chk("next_busy", busy, (nxt != 3'b111));
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; ch_en = '0; sel_ready = 1'b0;
        step(3);
        chk("rst_sel", sel, 3'b111);
        chk("rst_valid", sel_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        resetn = 1'b1;
        step(1);
        pulse_start();
        step(1);
        chk("start_mask0_busy", busy, 0);
        chk("start_mask0_sel", sel, 3'b111);

        // full scan, then stop on the next channel
        ch_en = 6'b111111; sel_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 6; c++)
            run_ch(3'(c), 3'((c + 1) % 6), c == 5);
        stop = 1'b1;
        run_ch(3'd0, 3'b111, 1'b0);
        stop = 1'b0;

        // sparse mask; mask change mid-dwell applies only at the handshake
        ch_en = 6'b100100;
        pulse_start();
        run_ch(3'd2, 3'd5, 1'b0);
        run_ch(3'd5, 3'd2, 1'b1);
        run_ch(3'd2, 3'd5, 1'b0);
        ch_en = 6'b001000;
        run_ch(3'd5, 3'd3, 1'b1);
        run_ch(3'd3, 3'd3, 1'b1);
        stop = 1'b1;
        run_ch(3'd3, 3'b111, 1'b1);
        stop = 1'b0;

        // backpressure at sel=1, then stop and a single handshake
        ch_en = 6'b111111;
        pulse_start();
        run_ch(3'd0, 3'd1, 1'b0);
        sel_ready = 1'b0;
        step(4);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("bp_sel", sel, 1);
            chk("bp_valid", sel_valid, 1);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_hold_sel", sel, 1);
        chk("stop_hold_busy", busy, 1);
        sel_ready = 1'b1;
        step(1);
        chk("stop_idle_sel", sel, 3'b111);
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_valid", sel_valid, 0);
        chk("stop_idle_fd", frame_done, 0);

        // asynchronous reset during dwell at sel=3
        pulse_start();
        run_ch(3'd0, 3'd1, 1'b0);
        run_ch(3'd1, 3'd2, 1'b0);
        run_ch(3'd2, 3'd3, 1'b0);
        step(2);
        resetn = 1'b0;
        #1;
        chk("async_rst_sel", sel, 3'b111);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", sel_valid, 0);
        step(1);
        resetn = 1'b1;
        step(1);

        // mask cleared during offer
        sel_ready = 1'b0;
        pulse_start();
        step(4);
        chk("clr_offer_valid", sel_valid, 1);
        ch_en = '0;
        step(2);
        chk("clr_hold_sel", sel, 0);
        sel_ready = 1'b1;
        step(1);
        chk("clr_idle_sel", sel, 3'b111);
        chk("clr_idle_busy", busy, 0);

`ifdef MUXSEQ_TIMEOUT_EN
        ch_en = 6'b111111; sel_ready = 1'b0;
        pulse_start();
        step(4);
        step(15);
        chk("to_pre_sel", sel, 0);
        chk("to_pre_err", timeout_err, 0);
        step(1);
        chk("to_err", timeout_err, 1);
        chk("to_adv_sel", sel, 1);
        step(1);
        chk("to_err_pulse", timeout_err, 0);
        step(3);
        step(15);
        sel_ready = 1'b1;
        step(1);
        chk("to_ready_last_sel", sel, 2);
        chk("to_ready_last_err", timeout_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
